// File: rtl/snake_body_engine.sv
// snake_body_engine: snake head plus MAX_LEN-deep body shift register.
// Grows on request up to MAX_LEN, ignores reversals, detects wall and
// self collisions, and produces registered head/body hit flags for the
// pixel colour mux.
// Optional macro WRAP_EN: moves past an edge wrap to the opposite edge
// instead of being blocked, and wall_hit stays 0.

module snake_body_engine #(
   parameter int  CELL     = 5,
   parameter int  BIT      = 10,
   parameter int  MAX_LEN  = 16,
   parameter int  INIT_LEN = 4,
   parameter int  X_START  = 320,
   parameter int  Y_START  = 240,
   parameter int  SCREEN_W = 640,
   parameter int  SCREEN_H = 480,
   localparam int LW       = $clog2(MAX_LEN + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           update,
   input  logic [2:0]     direction,
   input  logic           grow,
   input  logic [1:0]     game_state,
   input  logic [BIT-1:0] x_pos,
   input  logic [BIT-1:0] y_pos,
   output logic           snake_head_active,
   output logic           snake_body_active,
   output logic           self_hit,
   output logic           wall_hit,
   output logic [LW-1:0]  length,
   output logic [2:0]     rgb
);

   localparam logic [2:0]     DIR_IDLE  = 3'd0;
   localparam logic [2:0]     DIR_UP    = 3'd1;
   localparam logic [2:0]     DIR_DOWN  = 3'd2;
   localparam logic [2:0]     DIR_LEFT  = 3'd3;
   localparam logic [2:0]     DIR_RIGHT = 3'd4;
   localparam logic [1:0]     GS_PLAY   = 2'd1;
   localparam logic [1:0]     GS_OVER   = 2'd3;
   localparam logic [BIT:0]   CELL_E    = (BIT+1)'(CELL);
   localparam logic [BIT:0]   W_E       = (BIT+1)'(SCREEN_W);
   localparam logic [BIT:0]   H_E       = (BIT+1)'(SCREEN_H);
   localparam logic [BIT-1:0] CELL_B    = BIT'(CELL);
   localparam logic [BIT-1:0] OFF_X     = BIT'(SCREEN_W + CELL);
   localparam logic [BIT-1:0] OFF_Y     = BIT'(SCREEN_H + CELL);

   logic [BIT-1:0] hx_q, hy_q;
   logic [BIT-1:0] segx_q [MAX_LEN];
   logic [BIT-1:0] segy_q [MAX_LEN];
   logic [LW-1:0]  len_q, len_d;
   logic           grow_pend_q, grow_pend_d;
   logic [2:0]     last_dir_q, last_dir_d;
   logic           head_act_q, head_act_d;
   logic           body_act_q, body_act_d;
   logic           self_hit_q, self_hit_d;
   logic           wall_hit_q, wall_hit_d;

   logic [2:0]     dir_dec, eff_dir;
   logic           reversal, accept, edge_out, blocked, move, growing, hit;
   logic [LW-1:0]  limit;
   logic [BIT:0]   hx_e, hy_e;
   logic [BIT-1:0] nx, ny;

   // Box test of a pixel against a CELL x CELL square, one bit wider so sums never wrap.
   function automatic logic in_cell(input logic [BIT-1:0] px, input logic [BIT-1:0] py,
                                    input logic [BIT-1:0] cx, input logic [BIT-1:0] cy);
      logic [BIT:0] pxe, pye, cxe, cye;
      pxe = {1'b0, px};
      pye = {1'b0, py};
      cxe = {1'b0, cx};
      cye = {1'b0, cy};
      return (pxe >= cxe) && (pxe < cxe + CELL_E) && (pye >= cye) && (pye < cye + CELL_E);
   endfunction

   // Direction filtering, next head, edge handling and collision checks.
   always_comb begin
      dir_dec  = (direction >= DIR_UP && direction <= DIR_RIGHT) ? direction : DIR_IDLE;
      reversal = (dir_dec == DIR_UP    && last_dir_q == DIR_DOWN)  ||
                 (dir_dec == DIR_DOWN  && last_dir_q == DIR_UP)    ||
                 (dir_dec == DIR_LEFT  && last_dir_q == DIR_RIGHT) ||
                 (dir_dec == DIR_RIGHT && last_dir_q == DIR_LEFT);
      eff_dir  = reversal ? last_dir_q : dir_dec;
      accept   = (game_state == GS_PLAY) && update && (eff_dir != DIR_IDLE);
      hx_e     = {1'b0, hx_q};
      hy_e     = {1'b0, hy_q};
      nx       = hx_q;
      ny       = hy_q;
      edge_out = 1'b0;
      case (eff_dir)
         DIR_UP:    begin edge_out = hy_e < CELL_E;                ny = hy_q - CELL_B; end
         DIR_DOWN:  begin edge_out = hy_e + CELL_E > H_E - CELL_E; ny = hy_q + CELL_B; end
         DIR_LEFT:  begin edge_out = hx_e < CELL_E;                nx = hx_q - CELL_B; end
         DIR_RIGHT: begin edge_out = hx_e + CELL_E > W_E - CELL_E; nx = hx_q + CELL_B; end
         default:   edge_out = 1'b0;
      endcase
`ifdef WRAP_EN
      if (edge_out) begin
         case (eff_dir)
            DIR_UP:    ny = BIT'(SCREEN_H - CELL);
            DIR_DOWN:  ny = '0;
            DIR_LEFT:  nx = BIT'(SCREEN_W - CELL);
            DIR_RIGHT: nx = '0;
            default:   ;
         endcase
      end
      blocked = 1'b0;
`else
      blocked = edge_out;
`endif
      move    = accept && !blocked;
      growing = (grow_pend_q || grow) && (len_q < LW'(MAX_LEN));
      // A growing snake keeps its tail, so the tail cell stays occupied.
      limit   = growing ? len_q : len_q - LW'(1);
      hit     = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (LW'(i) < limit && segx_q[i] == nx && segy_q[i] == ny) hit = 1'b1;
      end

      self_hit_d  = move && hit;
      wall_hit_d  = accept && blocked;
      len_d       = (move && growing) ? len_q + LW'(1) : len_q;
      grow_pend_d = move ? 1'b0 : (grow_pend_q || grow);
      last_dir_d  = (accept && !reversal) ? eff_dir : last_dir_q;
   end

   // Pixel hit flags from the current (pre-move) positions.
   always_comb begin
      head_act_d = in_cell(x_pos, y_pos, hx_q, hy_q);
      body_act_d = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (LW'(i) < len_q && in_cell(x_pos, y_pos, segx_q[i], segy_q[i])) body_act_d = 1'b1;
      end
   end

   // Snake state; GAME_OVER restarts exactly like reset.
   always_ff @(posedge clk) begin
      if (reset || game_state == GS_OVER) begin
         hx_q        <= BIT'(X_START);
         hy_q        <= BIT'(Y_START);
         for (int i = 0; i < MAX_LEN; i++) begin
            segx_q[i] <= OFF_X;
            segy_q[i] <= OFF_Y;
         end
         len_q       <= LW'(INIT_LEN);
         grow_pend_q <= 1'b0;
         last_dir_q  <= DIR_IDLE;
         head_act_q  <= 1'b0;
         body_act_q  <= 1'b0;
         self_hit_q  <= 1'b0;
         wall_hit_q  <= 1'b0;
      end else begin
         len_q       <= len_d;
         grow_pend_q <= grow_pend_d;
         last_dir_q  <= last_dir_d;
         head_act_q  <= head_act_d;
         body_act_q  <= body_act_d;
         self_hit_q  <= self_hit_d;
         wall_hit_q  <= wall_hit_d;
         if (move) begin
            hx_q      <= nx;
            hy_q      <= ny;
            segx_q[0] <= hx_q;
            segy_q[0] <= hy_q;
            for (int i = 1; i < MAX_LEN; i++) begin
               segx_q[i] <= segx_q[i-1];
               segy_q[i] <= segy_q[i-1];
            end
         end
      end
   end

   assign snake_head_active = head_act_q;
   assign snake_body_active = body_act_q;
   assign self_hit          = self_hit_q;
   assign wall_hit          = wall_hit_q;
   assign length            = len_q;
   assign rgb               = 3'b010;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: a default instance (MAX_LEN=16) and a
// MAX_LEN=6 instance share stimulus; a cell-list model tracks both.
module tb_snake_body_engine;

   logic       clk = 1'b0;
   logic       reset, update, grow;
   logic [2:0] direction;
   logic [1:0] game_state;
   logic [9:0] x_pos, y_pos;
   logic       ha [2];
   logic       ba [2];
   logic       sh [2];
   logic       wh [2];
   logic [4:0] len0;
   logic [2:0] len1;
   logic [2:0] rgb0, rgb1;

   int checks = 0;
   int failures = 0;

   int mx [2];
   int my [2];
   int sx [2][64];
   int sy [2][64];
   int ml [2];
   int gp [2];
   int ld [2];
   int maxl [2] = '{16, 6};
   bit exp_ha [2];
   bit exp_ba [2];
   bit exp_sh [2];
   bit exp_wh [2];

   always #5 clk = ~clk;

   snake_body_engine u_dut0 (
      .clk(clk), .reset(reset), .update(update), .direction(direction), .grow(grow),
      .game_state(game_state), .x_pos(x_pos), .y_pos(y_pos),
      .snake_head_active(ha[0]), .snake_body_active(ba[0]), .self_hit(sh[0]),
      .wall_hit(wh[0]), .length(len0), .rgb(rgb0));

   snake_body_engine #(.MAX_LEN(6)) u_dut1 (
      .clk(clk), .reset(reset), .update(update), .direction(direction), .grow(grow),
      .game_state(game_state), .x_pos(x_pos), .y_pos(y_pos),
      .snake_head_active(ha[1]), .snake_body_active(ba[1]), .self_hit(sh[1]),
      .wall_hit(wh[1]), .length(len1), .rgb(rgb1));

   function automatic bit in_box(int px, int py, int cx, int cy);
      return px >= cx && px < cx + 5 && py >= cy && py < cy + 5;
   endfunction

   // Reference: head plus list of occupied cells, stepped once per clock.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (reset || game_state == 2'd3) begin
            mx[k] = 320; my[k] = 240;
            for (int i = 0; i < 64; i++) begin sx[k][i] = 645; sy[k][i] = 485; end
            ml[k] = 4; gp[k] = 0; ld[k] = 0;
            exp_ha[k] = 0; exp_ba[k] = 0; exp_sh[k] = 0; exp_wh[k] = 0;
         end else begin
            int px, py, d, e, nx, ny, lim;
            bit g, opp, out, moved, growing;
            px = int'(x_pos); py = int'(y_pos);
            exp_ha[k] = in_box(px, py, mx[k], my[k]);
            exp_ba[k] = 0;
            for (int i = 0; i < ml[k]; i++)
               if (in_box(px, py, sx[k][i], sy[k][i])) exp_ba[k] = 1;
            exp_sh[k] = 0; exp_wh[k] = 0;
            g = (gp[k] != 0) || grow;
            moved = 0;
            if (game_state == 2'd1 && update) begin
               d = (direction >= 1 && direction <= 4) ? int'(direction) : 0;
               opp = (d == 1 && ld[k] == 2) || (d == 2 && ld[k] == 1) ||
                     (d == 3 && ld[k] == 4) || (d == 4 && ld[k] == 3);
               e = opp ? ld[k] : d;
               if (e != 0) begin
                  if (!opp) ld[k] = e;
                  nx = mx[k]; ny = my[k];
                  case (e)
                     1: ny -= 5;
                     2: ny += 5;
                     3: nx -= 5;
                     default: nx += 5;
                  endcase
                  out = nx < 0 || nx > 635 || ny < 0 || ny > 475;
`ifdef WRAP_EN
                  if (nx < 0) nx = 635;
                  if (nx > 635) nx = 0;
                  if (ny < 0) ny = 475;
                  if (ny > 475) ny = 0;
                  out = 0;
`endif
                  if (out) exp_wh[k] = 1;
                  else begin
                     growing = g && ml[k] < maxl[k];
                     lim = growing ? ml[k] : ml[k] - 1;
                     for (int i = 0; i < lim; i++)
                        if (sx[k][i] == nx && sy[k][i] == ny) exp_sh[k] = 1;
                     for (int i = 63; i > 0; i--) begin
                        sx[k][i] = sx[k][i-1]; sy[k][i] = sy[k][i-1];
                     end
                     sx[k][0] = mx[k]; sy[k][0] = my[k];
                     mx[k] = nx; my[k] = ny;
                     if (growing) ml[k]++;
                     moved = 1;
                  end
               end
            end
            gp[k] = moved ? 0 : int'(g);
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; game_state = 0; update = 0; grow = 0; direction = 0; x_pos = 0; y_pos = 0;
      cycle(); cycle();
      checks++;
      if (len0 !== 5'd4 || len1 !== 3'd4) begin
         failures++; $display("FAIL reset_length got=%0d/%0d exp=4/4", len0, len1);
      end
      checks++;
      if ({ha[0], ba[0], sh[0], wh[0]} !== 4'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=0000", {ha[0], ba[0], sh[0], wh[0]});
      end
      checks++;
      if (rgb0 !== 3'b010) begin
         failures++; $display("FAIL rgb got=%b exp=010", rgb0);
      end
      reset = 0; game_state = 1; x_pos = 320; y_pos = 240;
      cycle();
      checks++;
      if (ha[0] !== 1'b1) begin
         failures++; $display("FAIL reset_head got=%b exp=1", ha[0]);
      end
   endtask

   task automatic test_move_right();
      direction = 4;
      for (int i = 0; i < 3; i++) begin update = 1; cycle(); end
      update = 0;
      x_pos = 335; y_pos = 240; cycle();
      checks++;
      if (ha[0] !== 1'b1) begin failures++; $display("FAIL move_head335 got=%b exp=1", ha[0]); end
      x_pos = 330; cycle();
      checks++;
      if (ha[0] !== 1'b0 || ba[0] !== 1'b1) begin
         failures++; $display("FAIL move_seg0 got=%b%b exp=01", ha[0], ba[0]);
      end
      x_pos = 325; cycle();
      checks++;
      if (ba[0] !== 1'b1) begin failures++; $display("FAIL move_seg1 got=%b exp=1", ba[0]); end
      x_pos = 340; cycle();
      checks++;
      if (ha[0] !== 1'b0 || ba[0] !== 1'b0 || len0 !== 5'd4) begin
         failures++; $display("FAIL move_ahead got=%b%b len=%0d exp=00 len=4", ha[0], ba[0], len0);
      end
   endtask

   task automatic test_reversal();
      direction = 3; update = 1; cycle(); update = 0;
      x_pos = 340; y_pos = 240; cycle();
      checks++;
      if (ha[0] !== 1'b1) begin failures++; $display("FAIL reversal_ignored got=%b exp=1", ha[0]); end
      direction = 1; update = 1; cycle(); update = 0;
      y_pos = 235; cycle();
      checks++;
      if (ha[0] !== 1'b1) begin failures++; $display("FAIL turn_up got=%b exp=1", ha[0]); end
      y_pos = 240; cycle();
      checks++;
      if (ha[0] !== 1'b0 || ba[0] !== 1'b1) begin
         failures++; $display("FAIL turn_up_body got=%b%b exp=01", ha[0], ba[0]);
      end
   endtask

   task automatic test_grow();
      grow = 1; cycle(); grow = 0;
      direction = 1; update = 1; cycle(); update = 0;
      checks++;
      if (len0 !== 5'd5 || len1 !== 3'd5) begin
         failures++; $display("FAIL grow_first got=%0d/%0d exp=5/5", len0, len1);
      end
      update = 1; cycle(); update = 0;
      checks++;
      if (len0 !== 5'd5 || len1 !== 3'd5) begin
         failures++; $display("FAIL grow_second got=%0d/%0d exp=5/5", len0, len1);
      end
      for (int i = 0; i < 3; i++) begin grow = 1; update = 1; cycle(); end
      grow = 0; update = 0; cycle();
      checks++;
      if (len0 !== 5'd8 || len1 !== 3'd6) begin
         failures++; $display("FAIL grow_saturate got=%0d/%0d exp=8/6", len0, len1);
      end
   endtask

   task automatic test_wall();
      direction = 3;
      for (int i = 0; i < 68; i++) begin update = 1; cycle(); end
      update = 0;
      x_pos = 0; y_pos = 210; cycle();
      checks++;
      if (ha[0] !== 1'b1) begin failures++; $display("FAIL wall_reach got=%b exp=1", ha[0]); end
      update = 1; cycle(); update = 0;
      checks++;
`ifdef WRAP_EN
      if (wh[0] !== 1'b0) begin failures++; $display("FAIL wall_pulse got=%b exp=0", wh[0]); end
`else
      if (wh[0] !== 1'b1) begin failures++; $display("FAIL wall_pulse got=%b exp=1", wh[0]); end
`endif
`ifdef WRAP_EN
      x_pos = 635;
`endif
      cycle();
      checks++;
      if (wh[0] !== 1'b0) begin failures++; $display("FAIL wall_one_cycle got=%b exp=0", wh[0]); end
      cycle();
      checks++;
      if (ha[0] !== 1'b1) begin failures++; $display("FAIL wall_head_pos got=%b exp=1", ha[0]); end
   endtask

   task automatic test_self_hit();
      game_state = 3; cycle(); game_state = 1;
      grow = 1; direction = 4; update = 1; cycle(); grow = 0;
      direction = 2; cycle();
      direction = 3; cycle();
      direction = 1; cycle();
      update = 0;
      checks++;
      if (sh[0] !== 1'b1 || sh[1] !== 1'b1 || len0 !== 5'd5) begin
         failures++; $display("FAIL self_hit got=%b%b len=%0d exp=11 len=5", sh[0], sh[1], len0);
      end
      cycle();
      checks++;
      if (sh[0] !== 1'b0) begin failures++; $display("FAIL self_hit_pulse got=%b exp=0", sh[0]); end
   endtask

   task automatic test_sweep_game_over();
      game_state = 3; cycle(); game_state = 1;
      direction = 4;
      for (int i = 0; i < 3; i++) begin update = 1; cycle(); end
      update = 0; y_pos = 240;
      for (int x = 334; x <= 341; x++) begin
         x_pos = 10'(x); cycle();
         checks++;
         if (ha[0] !== ((x >= 335 && x <= 339) ? 1'b1 : 1'b0)) begin
            failures++; $display("FAIL sweep x=%0d got=%b", x, ha[0]);
         end
      end
      x_pos = 335; cycle();
      x_pos = 400; #1;
      checks++;
      if (ha[0] !== 1'b1) begin failures++; $display("FAIL pixel_latency got=%b exp=1", ha[0]); end
      game_state = 3; x_pos = 335; cycle(); game_state = 1;
      checks++;
      if (len0 !== 5'd4 || ha[0] !== 1'b0 || ba[0] !== 1'b0) begin
         failures++; $display("FAIL game_over got len=%0d flags=%b%b exp len=4 flags=00", len0, ha[0], ba[0]);
      end
      for (int x = 315; x <= 340; x += 5) begin
         x_pos = 10'(x); cycle();
         checks++;
         if (ha[0] !== ((x == 320) ? 1'b1 : 1'b0) || ba[0] !== 1'b0) begin
            failures++; $display("FAIL post_game_over x=%0d got=%b%b", x, ha[0], ba[0]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         int r, sel, bx, by;
         r = int'($urandom_range(0, 199));
         reset = (r == 0);
         game_state = (r < 3) ? 2'd3 : ((r < 8) ? 2'd0 : 2'd1);
         direction = 3'($urandom_range(0, 7));
         update = ($urandom_range(0, 2) == 0);
         grow = ($urandom_range(0, 6) == 0);
         sel = int'($urandom_range(0, ml[0]));
         bx = (sel == 0) ? mx[0] : sx[0][sel-1];
         by = (sel == 0) ? my[0] : sy[0][sel-1];
         bx = bx + int'($urandom_range(0, 9)) - 2;
         by = by + int'($urandom_range(0, 9)) - 2;
         x_pos = 10'((bx < 0) ? 0 : bx);
         y_pos = 10'((by < 0) ? 0 : by);
         cycle();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (ha[k] !== exp_ha[k] || ba[k] !== exp_ba[k] || sh[k] !== exp_sh[k] || wh[k] !== exp_wh[k]) begin
               failures++;
               $display("FAIL rand_flags n=%0d inst=%0d got=%b%b%b%b exp=%b%b%b%b", n, k,
                        ha[k], ba[k], sh[k], wh[k], exp_ha[k], exp_ba[k], exp_sh[k], exp_wh[k]);
            end
         end
         checks++;
         if (len0 !== 5'(ml[0]) || len1 !== 3'(ml[1])) begin
            failures++; $display("FAIL rand_length n=%0d got=%0d/%0d exp=%0d/%0d", n, len0, len1, ml[0], ml[1]);
         end
      end
      reset = 0;
   endtask

   initial begin
      test_reset();
      test_move_right();
      test_reversal();
      test_grow();
      test_wall();
      test_self_hit();
      test_sweep_game_over();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
